// File: rtl/multiplexor_display_pkg.sv
// multiplexor_pkg: shared states, idle levels and brightness helper for the display scanner
package multiplexor_pkg;
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} estado_t;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] ANODO_OFF = 4'b1111;
   function automatic int brillo_len(input int show_len, input logic [1:0] b);
      int l;
      l = ((int'(b) + 1) * show_len) / 4;
      return (l < 1) ? 1 : l;
   endfunction
endpackage

// File: rtl/multiplexor_display_contador_ranura.sv
// contador_ranura: per-slot cycle counter and digit index, exposing next values so outputs can be registered
module contador_ranura #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic                           run,
   output logic [$clog2(REFRESH_DIV)-1:0] cnt_nxt,
   output logic [1:0]                     digito,
   output logic [1:0]                     digito_nxt,
   output logic                           fin_ranura
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [CW-1:0] cnt;
   // next count: held at zero while idle, wraps at slot end, cleared when disabled
   always_comb begin
      fin_ranura = run && (cnt == CW'(REFRESH_DIV - 1));
      cnt_nxt = (!en || !run || fin_ranura) ? '0 : cnt + 1'b1;
      digito_nxt = !en ? 2'd0 : digito + {1'b0, fin_ranura};
   end
   // slot counter and digit index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         digito <= 2'd0;
      end else begin
         cnt <= cnt_nxt;
         digito <= digito_nxt;
      end
   end
endmodule

// File: rtl/multiplexor_display.sv
// multiplexor_display: 4-digit common-anode scan driver with per-frame snapshot; MULTIPLEXOR_BRILLO_EN adds brillo dimming
module multiplexor_display
   import multiplexor_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
`ifdef MULTIPLEXOR_BRILLO_EN
   input  logic [1:0] brillo,
`endif
   input  logic [7:0] catodo1,
   input  logic [7:0] catodo2,
   input  logic [7:0] catodo3,
   input  logic [7:0] catodo4,
   output logic [3:0] anodo,
   output logic [7:0] catodo,
   output logic [1:0] digito,
   output logic       fin_trama
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int SHOW_LEN = REFRESH_DIV - BLANK_CYCLES;
   estado_t estado, estado_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0] digito_nxt;
   logic fin_ranura, snap, fin_nxt, encendido;
   logic [3:0][7:0] sombra, sombra_nxt;
   logic [3:0] anodo_nxt;
   logic [7:0] catodo_nxt;
`ifdef MULTIPLEXOR_BRILLO_EN
   logic [1:0] brillo_q, brillo_nxt;
`endif

   contador_ranura #(.REFRESH_DIV(REFRESH_DIV)) u_contador (
      .clk(clk),
      .reset(reset),
      .en(en),
      .run(estado != IDLE),
      .cnt_nxt(cnt_nxt),
      .digito(digito),
      .digito_nxt(digito_nxt),
      .fin_ranura(fin_ranura)
   );

   // next state, snapshot and output values derived from the counter's next position
   always_comb begin
      fin_nxt = en && fin_ranura && (digito == 2'd3);
      snap = en && ((estado == IDLE) || fin_nxt);
      sombra_nxt = snap ? {catodo4, catodo3, catodo2, catodo1} : sombra;
`ifdef MULTIPLEXOR_BRILLO_EN
      brillo_nxt = snap ? brillo : brillo_q;
      encendido = int'(cnt_nxt) < BLANK_CYCLES + brillo_len(SHOW_LEN, brillo_nxt);
`else
      encendido = 1'b1;
`endif
      estado_nxt = !en ? IDLE : (int'(cnt_nxt) < BLANK_CYCLES) ? BLANK : SHOW;
      anodo_nxt = (estado_nxt == SHOW && encendido) ? ~(4'b0001 << digito_nxt) : ANODO_OFF;
      catodo_nxt = (estado_nxt == SHOW && encendido) ? sombra_nxt[digito_nxt] : SEG_OFF;
   end

   // state, shadow and registered outputs; reset darkens the display immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= IDLE;
         sombra <= {4{SEG_OFF}};
         anodo <= ANODO_OFF;
         catodo <= SEG_OFF;
         fin_trama <= 1'b0;
`ifdef MULTIPLEXOR_BRILLO_EN
         brillo_q <= 2'd3;
`endif
      end else begin
         estado <= estado_nxt;
         sombra <= sombra_nxt;
         anodo <= anodo_nxt;
         catodo <= catodo_nxt;
         fin_trama <= fin_nxt;
`ifdef MULTIPLEXOR_BRILLO_EN
         brillo_q <= brillo_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_multiplexor_display.sv
// tb_multiplexor_display: random scan stimulus checked against a frame-position model for two parameter sets
module tb_multiplexor_display;
   logic clk, reset, en;
   logic [1:0] brillo;
   logic [7:0] c1, c2, c3, c4;
   logic [3:0] an0, an1;
   logic [7:0] ca0, ca1;
   logic [1:0] dg0, dg1;
   logic ft0, ft1;
   int nchecks = 0;
   int nerrs = 0;
   int rr [2] = '{8, 4};
   int bb [2] = '{2, 1};
   bit act [2];
   int tm [2];
   logic [3:0][7:0] sn [2];
   logic [1:0] bs [2];

   multiplexor_display #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) u0 (
      .clk(clk), .reset(reset), .en(en),
`ifdef MULTIPLEXOR_BRILLO_EN
      .brillo(brillo),
`endif
      .catodo1(c1), .catodo2(c2), .catodo3(c3), .catodo4(c4),
      .anodo(an0), .catodo(ca0), .digito(dg0), .fin_trama(ft0)
   );

   multiplexor_display #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) u1 (
      .clk(clk), .reset(reset), .en(en),
`ifdef MULTIPLEXOR_BRILLO_EN
      .brillo(brillo),
`endif
      .catodo1(c1), .catodo2(c2), .catodo3(c3), .catodo4(c4),
      .anodo(an1), .catodo(ca1), .digito(dg1), .fin_trama(ft1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic take_snap(input int i);
      sn[i] = {c4, c3, c2, c1};
      bs[i] = brillo;
   endtask

   task automatic model_edge(input int i);
      if (reset || !en) act[i] = 1'b0;
      else if (!act[i]) begin
         act[i] = 1'b1;
         tm[i] = 0;
         take_snap(i);
      end else begin
         tm[i]++;
         if (tm[i] % (4 * rr[i]) == 0) take_snap(i);
      end
   endtask

   task automatic check_inst(input int i, input logic [3:0] an, input logic [7:0] ca, input logic [1:0] dg, input logic ft);
      int pos, d, c, lit;
      logic [3:0] ea;
      logic [7:0] ec;
      logic [1:0] ed;
      logic ef;
      ea = 4'hF;
      ec = 8'hFF;
      ed = 2'd0;
      ef = 1'b0;
      if (act[i]) begin
         pos = tm[i] % (4 * rr[i]);
         d = pos / rr[i];
         c = pos % rr[i];
`ifdef MULTIPLEXOR_BRILLO_EN
         lit = ((int'(bs[i]) + 1) * (rr[i] - bb[i])) / 4;
         if (lit < 1) lit = 1;
`else
         lit = rr[i] - bb[i];
`endif
         ed = 2'(d);
         ef = (tm[i] > 0) && (pos == 0);
         if (c >= bb[i] && c - bb[i] < lit) begin
            ea = ~(4'b0001 << d);
            ec = sn[i][d];
         end
      end
      check($sformatf("anodo%0d", i), 32'(an), 32'(ea));
      check($sformatf("catodo%0d", i), 32'(ca), 32'(ec));
      check($sformatf("digito%0d", i), 32'(dg), 32'(ed));
      check($sformatf("fin_trama%0d", i), 32'(ft), 32'(ef));
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_anodo0"}, 32'(an0), 32'hF);
      check({tag, "_catodo0"}, 32'(ca0), 32'hFF);
      check({tag, "_digito0"}, 32'(dg0), 32'h0);
      check({tag, "_fin0"}, 32'(ft0), 32'h0);
      check({tag, "_anodo1"}, 32'(an1), 32'hF);
      check({tag, "_catodo1"}, 32'(ca1), 32'hFF);
   endtask

   task automatic step(input bit pulse_rst);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_inst(0, an0, ca0, dg0, ft0);
      check_inst(1, an1, ca1, dg1, ft1);
      if (pulse_rst) begin
         #2 reset = 1'b1;
         #1;
         check_dark("async_rst");
         act[0] = 1'b0;
         act[1] = 1'b0;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      en = 1'b0;
      brillo = 2'd3;
      {c1, c2, c3, c4} = {4{8'hFF}};
      act[0] = 1'b0;
      act[1] = 1'b0;
      #2;
      check_dark("reset");
      @(negedge clk);
      c1 = 8'h9F;
      c2 = 8'h25;
      c3 = 8'h0D;
      c4 = 8'h99;
      en = 1'b1;
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0);
         if (k == 2) begin
            check("first_show_anodo", 32'(an0), 32'hE);
            check("first_show_catodo", 32'(ca0), 32'h9F);
         end
         if (k == 20) c1 = 8'h00;
      end
      check("new_snap_anodo", 32'(an0), 32'hE);
      check("new_snap_catodo", 32'(ca0), 32'h00);
      check("corner_anodo", 32'(an1), 32'hD);
      check("corner_catodo", 32'(ca1), 32'h25);
      for (int k = 0; k < 40 && !((tm[0] % 32) / 8 == 1 && tm[0] % 8 >= 2); k++) step(1'b0);
      en = 1'b0;
      step(1'b0);
      check_dark("en_drop");
      c2 = 8'h42;
      en = 1'b1;
      for (int k = 0; k < 12; k++) step(1'b0);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: c1 = 8'($urandom);
               1: c2 = 8'($urandom);
               2: c3 = 8'($urandom);
               default: c4 = 8'($urandom);
            endcase
         end
         if ($urandom_range(0, 19) == 0) brillo = 2'($urandom);
         en = ($urandom_range(0, 59) != 0);
         step($urandom_range(0, 149) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end
endmodule

// File: doc/multiplexor_display.md
Name: multiplexor_display

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode 7-segment display.
- Sits directly downstream of the count-to-segment decoder and consumes its four 8-bit cathode patterns.
- Scans one digit at a time: a blanking gap, then the digit is shown. Drives the shared cathode bus and four active-low anodes.
- Snapshots all four patterns once per frame so a count changing mid-scan never tears.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Must be >= 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with every anode off (anti-ghosting). Must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces the display dark.
- catodo1  in  8  pattern for digit 0 (units); active-low, bit7=a..bit1=g, bit0=dp.
- catodo2  in  8  pattern for digit 1.
- catodo3  in  8  pattern for digit 2.
- catodo4  in  8  pattern for digit 3.
- anodo  out  4  active-low digit enables; bit i = digit i.
- catodo  out  8  active-low segment bus.
- digito  out  2  index of the current slot.
- fin_trama  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clock and reset: single clock domain (clk). reset is asynchronous and active-high.
- Reset values: state=IDLE, slot counter cnt=0, digito=0, anodo=4'b1111, catodo=8'hFF, fin_trama=0, shadow registers=8'hFF.
- States:
  - IDLE: outputs dark, cnt=0, digito=0.
  - BLANK: anodo=1111, catodo=FF.
  - SHOW: anodo = one-hot-low on digito; catodo = shadow[digito].
- Outputs are registered (Moore) and change on the same edge that the state changes.
- IDLE -> BLANK with cnt=0, digito=0 on the first edge where en=1. That edge also captures catodo1..4 into the shadow registers.
- Within a slot:
  - cnt runs 0..REFRESH_DIV-1.
  - cnt < BLANK_CYCLES is BLANK; otherwise SHOW.
  - SHOW length SHOW_LEN = REFRESH_DIV - BLANK_CYCLES.
- At cnt = REFRESH_DIV-1: cnt wraps to 0 and digito increments modulo 4, entering BLANK.
- Wrap 3 -> 0:
  - Fresh snapshot of catodo1..4.
  - fin_trama=1 for exactly that one cycle.
  - Entry from IDLE does not pulse fin_trama.
- Frame period = 4*REFRESH_DIV cycles.
- Input changes between snapshots have no effect on the outputs.
- en=0 in any state: next edge goes to IDLE (dark, cnt and digito cleared). No partial-slot completion.
- en re-asserted: restart at digit 0 BLANK with a new snapshot.
- reset mid-slot: outputs go dark immediately (asynchronous), without waiting for a clock edge.
- Counter width: $clog2(REFRESH_DIV). No overflow is possible given the parameter constraints.

Optional Feature:
- Macro: MULTIPLEXOR_BRILLO_EN
- Enabled:
  - Adds input port brillo [1:0], sampled together with the shadow registers at each snapshot.
  - Active SHOW cycles per slot = max(1, ((brillo+1)*SHOW_LEN)>>2).
  - Remaining SHOW cycles drive anodo=1111 and catodo=FF.
  - digito and fin_trama timing are unchanged.
- Disabled: the port is absent and the full SHOW_LEN is lit.

Decomposition:
- Shared package multiplexor_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_OFF = 8'hFF
  - ANODO_OFF = 4'b1111
- One natural sub-module: contador_ranura. It is the slot counter, emitting cnt, a slot-end strobe and the digit index.
- FSM, snapshot and output registers stay in the top module.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
1. Scan order:
   - Stimulus: catodo1=9F, catodo2=25, catodo3=0D, catodo4=99; en=1; release reset.
   - Required: after the entry edge, 2 cycles anodo=1111, then 6 cycles anodo=1110 with catodo=9F. Then 2 blank + 6 of 1101/25, then 1011/0D, then 0111/99.
   - fin_trama pulses once every 32 cycles.
2. Snapshot:
   - Stimulus: change catodo1 to 00 while digit 2 is showing.
   - Required: digit 0 shows 9F for the rest of this frame and 00 only after the next fin_trama.
3. Enable:
   - Stimulus: drop en during digit 1 SHOW.
   - Required: next edge gives anodo=1111, catodo=FF, digito=0, fin_trama=0. Re-raising en gives BLANK at digit 0, then the fresh patterns.
4. Async reset:
   - Stimulus: pulse reset between edges during SHOW.
   - Required: anodo=1111 and catodo=FF with no clock edge. Scanning resumes at digit 0 after release.
5. Parameter corner (BLANK_CYCLES=1, REFRESH_DIV=4):
   - Required: 1 blank + 3 show cycles per slot, and a 16-cycle frame.
6. Brightness (MULTIPLEXOR_BRILLO_EN):
   - Stimulus: brillo = 0, 1, 2, 3.
   - Required: lit cycles per slot = 1, 3, 4, 6 respectively. A brillo change mid-frame takes effect only at the next snapshot.
